keypad_operand_entry: RTL and testbench

//  Parametrised successor to the fixed keypad-to-CORDIC mapping stage. Consumes decoded key

---
 rtl/keypad_operand_entry_pkg.sv | 35 +++
 rtl/keypad_operand_entry_dec_accum.sv | 48 ++++
 rtl/keypad_operand_entry.sv | 213 +++++++++++++++++++++
 tb/tb_keypad_operand_entry.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_operand_entry_pkg.sv
// Shared definitions for the keypad operand entry block: key codes, FSM and
// accumulator mode encodings, and a constant clog2 helper.
package keypad_pkg;

    localparam logic [3:0] KEY_NEXT = 4'hA;
    localparam logic [3:0] KEY_BKSP = 4'hB;
    localparam logic [3:0] KEY_CLR  = 4'hC;
    localparam logic [3:0] KEY_GO   = 4'hD;
    localparam logic [3:0] KEY_OP   = 4'hE;
    localparam logic [3:0] KEY_NEG  = 4'hF;

    typedef enum logic {
        ST_ENTRY = 1'b0,
        ST_HOLD  = 1'b1
    } state_e;

    typedef enum logic {
        ACC_PUSH = 1'b0,
        ACC_POP  = 1'b1
    } acc_mode_e;

    function automatic int clog2(input int value);
        int res;
        res = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'd1 << i) < 32'(value)) begin
                res = i + 1;
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/keypad_operand_entry_dec_accum.sv
// Combinational decimal accumulator: pushes a digit (f*10+d, saturating at
// MAX_MAG) or pops one (f/10) on a single field magnitude.
module dec_accum
    import keypad_pkg::*;
#(
    parameter int               WIDTH   = 22,
    parameter logic [WIDTH-1:0] MAX_MAG = {WIDTH{1'b1}}
) (
    input  logic [WIDTH-1:0] mag,
    input  logic [3:0]       digit,
    input  acc_mode_e        mode,
    output logic [WIDTH-1:0] next_mag,
    output logic             sat
);

    logic [WIDTH+3:0] wide_s;

    // Push result with four guard bits so f*10+9 can never wrap.
    always_comb begin
        wide_s = ({4'b0000, mag} * (WIDTH+4)'(4'd10)) + {{WIDTH{1'b0}}, digit};
    end

    // Select push/pop result and flag saturation.
    always_comb begin
        next_mag = mag;
        sat      = 1'b0;
        case (mode)
            ACC_PUSH: begin
                if (wide_s > {4'b0000, MAX_MAG}) begin
                    next_mag = MAX_MAG;
                    sat      = 1'b1;
                end else begin
                    next_mag = wide_s[WIDTH-1:0];
                    sat      = 1'b0;
                end
            end
            ACC_POP: begin
                next_mag = mag / WIDTH'(4'd10);
                sat      = 1'b0;
            end
            default: begin
                next_mag = mag;
                sat      = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/keypad_operand_entry.sv
// Keypad operand entry: builds NUM_FIELDS decimal operands and an op code from
// key strobes and hands them downstream over valid/ready. Optional KEYPAD_NEG_EN adds per-field sign.
module keypad_operand_entry
    import keypad_pkg::*;
#(
    parameter int  NUM_FIELDS = 4,
    parameter int  WIDTH      = 22,
    parameter int  OP_W       = 2,
    localparam int SEL_W      = (clog2(NUM_FIELDS) < 1) ? 1 : clog2(NUM_FIELDS)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [3:0]                  key,
    input  logic                        key_valid,
    output logic [NUM_FIELDS*WIDTH-1:0] field_data,
    output logic [OP_W-1:0]             operation,
    output logic [SEL_W-1:0]            field_sel,
    output logic                        cmd_valid,
    input  logic                        cmd_ready,
    output logic                        ovf,
    output logic                        key_dropped
);

`ifdef KEYPAD_NEG_EN
    localparam logic [WIDTH-1:0] MAX_MAG = {1'b0, {(WIDTH-1){1'b1}}};
`else
    localparam logic [WIDTH-1:0] MAX_MAG = {WIDTH{1'b1}};
`endif

    state_e                      state_r, state_next_s;
    logic [WIDTH-1:0]            mag_r [NUM_FIELDS];
    logic [NUM_FIELDS*WIDTH-1:0] field_data_r;
    logic [OP_W-1:0]             operation_r, op_next_s;
    logic [SEL_W-1:0]            field_sel_r, sel_next_s;
    logic                        cmd_valid_r, cmd_valid_next_s;
    logic                        ovf_r, ovf_next_s;
    logic                        key_dropped_r, dropped_next_s;
    logic                        clear_all_s, field_we_s;
    logic [WIDTH-1:0]            cur_mag_s, mag_next_s, acc_mag_s, field_value_s;
    logic                        acc_sat_s;
    acc_mode_e                   acc_mode_s;

`ifdef KEYPAD_NEG_EN
    logic [NUM_FIELDS-1:0] sign_r;
    logic                  sign_next_s;

    function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] m, input logic neg);
        if (neg) begin
            return ~m + WIDTH'(1'b1);
        end else begin
            return m;
        end
    endfunction

    assign field_value_s = apply_sign(mag_next_s, sign_next_s);
`else
    assign field_value_s = mag_next_s;
`endif

    assign cur_mag_s  = mag_r[field_sel_r];
    assign acc_mode_s = (key == KEY_BKSP) ? ACC_POP : ACC_PUSH;

    dec_accum #(
        .WIDTH   (WIDTH),
        .MAX_MAG (MAX_MAG)
    ) u_dec_accum (
        .mag      (cur_mag_s),
        .digit    (key),
        .mode     (acc_mode_s),
        .next_mag (acc_mag_s),
        .sat      (acc_sat_s)
    );

    // Next-state and key decode; every key in HOLD is dropped, transfer clears the entry.
    always_comb begin
        state_next_s     = state_r;
        sel_next_s       = field_sel_r;
        op_next_s        = operation_r;
        ovf_next_s       = ovf_r;
        cmd_valid_next_s = cmd_valid_r;
        dropped_next_s   = 1'b0;
        clear_all_s      = 1'b0;
        field_we_s       = 1'b0;
        mag_next_s       = cur_mag_s;
`ifdef KEYPAD_NEG_EN
        sign_next_s      = sign_r[field_sel_r];
`endif
        case (state_r)
            ST_ENTRY: begin
                if (key_valid) begin
                    if (key <= 4'd9) begin
                        field_we_s = 1'b1;
                        mag_next_s = acc_mag_s;
                        ovf_next_s = ovf_r | acc_sat_s;
                    end else begin
                        case (key)
                            KEY_NEXT: begin
                                if (field_sel_r == SEL_W'(NUM_FIELDS - 1)) begin
                                    sel_next_s = {SEL_W{1'b0}};
                                end else begin
                                    sel_next_s = field_sel_r + SEL_W'(1'b1);
                                end
                            end
                            KEY_BKSP: begin
                                field_we_s = 1'b1;
                                mag_next_s = acc_mag_s;
                            end
                            KEY_CLR: begin
                                field_we_s  = 1'b1;
                                mag_next_s  = {WIDTH{1'b0}};
                                ovf_next_s  = 1'b0;
`ifdef KEYPAD_NEG_EN
                                sign_next_s = 1'b0;
`endif
                            end
                            KEY_GO: begin
                                cmd_valid_next_s = 1'b1;
                                state_next_s     = ST_HOLD;
                            end
                            KEY_OP: begin
                                op_next_s = operation_r + OP_W'(1'b1);
                            end
`ifdef KEYPAD_NEG_EN
                            KEY_NEG: begin
                                field_we_s  = 1'b1;
                                sign_next_s = ~sign_r[field_sel_r];
                            end
`endif
                            default: begin
                                field_we_s = 1'b0;
                            end
                        endcase
                    end
                end else begin
                    field_we_s = 1'b0;
                end
            end
            ST_HOLD: begin
                dropped_next_s = key_valid;
                if (cmd_ready) begin
                    cmd_valid_next_s = 1'b0;
                    clear_all_s      = 1'b1;
                    sel_next_s       = {SEL_W{1'b0}};
                    ovf_next_s       = 1'b0;
                    state_next_s     = ST_ENTRY;
                end else begin
                    state_next_s = ST_HOLD;
                end
            end
            default: begin
                state_next_s = ST_ENTRY;
            end
        endcase
    end

    // Control and status registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r       <= ST_ENTRY;
            field_sel_r   <= {SEL_W{1'b0}};
            operation_r   <= {OP_W{1'b0}};
            cmd_valid_r   <= 1'b0;
            ovf_r         <= 1'b0;
            key_dropped_r <= 1'b0;
        end else begin
            state_r       <= state_next_s;
            field_sel_r   <= sel_next_s;
            operation_r   <= op_next_s;
            cmd_valid_r   <= cmd_valid_next_s;
            ovf_r         <= ovf_next_s;
            key_dropped_r <= dropped_next_s;
        end
    end

    // Field magnitudes plus the registered two's-complement view driven to the port.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            field_data_r <= {(NUM_FIELDS*WIDTH){1'b0}};
            for (int i = 0; i < NUM_FIELDS; i++) begin
                mag_r[i] <= {WIDTH{1'b0}};
            end
`ifdef KEYPAD_NEG_EN
            sign_r <= {NUM_FIELDS{1'b0}};
`endif
        end else if (clear_all_s) begin
            field_data_r <= {(NUM_FIELDS*WIDTH){1'b0}};
            for (int i = 0; i < NUM_FIELDS; i++) begin
                mag_r[i] <= {WIDTH{1'b0}};
            end
`ifdef KEYPAD_NEG_EN
            sign_r <= {NUM_FIELDS{1'b0}};
`endif
        end else if (field_we_s) begin
            for (int i = 0; i < NUM_FIELDS; i++) begin
                if (SEL_W'(i) == field_sel_r) begin
                    mag_r[i]                     <= mag_next_s;
                    field_data_r[i*WIDTH +: WIDTH] <= field_value_s;
`ifdef KEYPAD_NEG_EN
                    sign_r[i]                    <= sign_next_s;
`endif
                end
            end
        end
    end

    assign field_data  = field_data_r;
    assign operation   = operation_r;
    assign field_sel   = field_sel_r;
    assign cmd_valid   = cmd_valid_r;
    assign ovf         = ovf_r;
    assign key_dropped = key_dropped_r;

endmodule

// File: tb/tb_keypad_operand_entry.sv
// Self-checking bench for keypad_operand_entry (WIDTH=8, 3 fields): directed
// cases plus random key/ready traffic against a behavioural model. Honours KEYPAD_NEG_EN.
module tb_keypad_operand_entry;

    localparam int NF = 3;
    localparam int W  = 8;
    localparam int OW = 2;
    localparam int SW = 2;
`ifdef KEYPAD_NEG_EN
    localparam int MAXV = (1 << (W - 1)) - 1;
`else
    localparam int MAXV = (1 << W) - 1;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [3:0]    key;
    logic          key_valid;
    logic          cmd_ready;
    logic [NF*W-1:0] field_data;
    logic [OW-1:0] operation;
    logic [SW-1:0] field_sel;
    logic          cmd_valid;
    logic          ovf;
    logic          key_dropped;

    int n_checks = 0;
    int n_fail   = 0;

    int m_mag [NF];
    bit m_sgn [NF];
    int m_sel, m_op;
    bit m_ovf, m_hold, m_drop;

    always #5 clk = ~clk;

    keypad_operand_entry #(
        .NUM_FIELDS (NF),
        .WIDTH      (W),
        .OP_W       (OW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .key         (key),
        .key_valid   (key_valid),
        .field_data  (field_data),
        .operation   (operation),
        .field_sel   (field_sel),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .ovf         (ovf),
        .key_dropped (key_dropped)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int exp_field(input int i);
        if (m_sgn[i]) return ((1 << W) - m_mag[i]) % (1 << W);
        else return m_mag[i];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NF; i++) begin
            m_mag[i] = 0;
            m_sgn[i] = 1'b0;
        end
        m_sel = 0; m_op = 0; m_ovf = 1'b0; m_hold = 1'b0; m_drop = 1'b0;
    endtask

    task automatic model_step(input bit kv, input int k, input bit rdy);
        int v;
        m_drop = 1'b0;
        if (m_hold) begin
            m_drop = kv;
            if (rdy) begin
                for (int i = 0; i < NF; i++) begin
                    m_mag[i] = 0;
                    m_sgn[i] = 1'b0;
                end
                m_sel = 0; m_ovf = 1'b0; m_hold = 1'b0;
            end
        end else if (kv) begin
            if (k <= 9) begin
                v = m_mag[m_sel] * 10 + k;
                if (v > MAXV) begin
                    m_mag[m_sel] = MAXV;
                    m_ovf = 1'b1;
                end else begin
                    m_mag[m_sel] = v;
                end
            end else begin
                case (k)
                    10: m_sel = (m_sel + 1) % NF;
                    11: m_mag[m_sel] = m_mag[m_sel] / 10;
                    12: begin m_mag[m_sel] = 0; m_sgn[m_sel] = 1'b0; m_ovf = 1'b0; end
                    13: m_hold = 1'b1;
                    14: m_op = (m_op + 1) % (1 << OW);
`ifdef KEYPAD_NEG_EN
                    15: m_sgn[m_sel] = !m_sgn[m_sel];
`endif
                    default: ;
                endcase
            end
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < NF; i++) begin
            check_eq($sformatf("field%0d", i), 64'(field_data[i*W +: W]), 64'(exp_field(i)));
        end
        check_eq("operation", 64'(operation), 64'(m_op));
        check_eq("field_sel", 64'(field_sel), 64'(m_sel));
        check_eq("cmd_valid", 64'(cmd_valid), 64'(m_hold));
        check_eq("ovf", 64'(ovf), 64'(m_ovf));
        check_eq("key_dropped", 64'(key_dropped), 64'(m_drop));
    endtask

    task automatic cycle(input bit kv, input logic [3:0] k, input bit rdy);
        key = k; key_valid = kv; cmd_ready = rdy;
        @(posedge clk);
        model_step(kv, int'(k), rdy);
        @(negedge clk);
        check_all();
    endtask

    task automatic press(input logic [3:0] k);
        cycle(1'b1, k, 1'b0);
    endtask

    initial begin
        logic [3:0] seq [];
        reset = 1'b0; key = 4'h0; key_valid = 1'b0; cmd_ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all();
        reset = 1'b1;
        cycle(1'b0, 4'h0, 1'b0);

        // Two fields by hand, then bump the op code.
        seq = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'hE};
        foreach (seq[i]) press(seq[i]);
        check_eq("t2_field0", 64'(field_data[0 +: W]), 64'd123);
        check_eq("t2_field1", 64'(field_data[W +: W]), 64'd45);
        check_eq("t2_sel", 64'(field_sel), 64'd1);

        // Commit and stall downstream; command must stay frozen.
        press(4'hD);
        repeat (5) begin
            cycle(1'b0, 4'h0, 1'b0);
            check_eq("t3_hold_valid", 64'(cmd_valid), 64'd1);
            check_eq("t3_hold_f0", 64'(field_data[0 +: W]), 64'd123);
        end
        press(4'h7);
        check_eq("t5_drop_pulse", 64'(key_dropped), 64'd1);
        check_eq("t5_drop_f1", 64'(field_data[W +: W]), 64'd45);
        cycle(1'b0, 4'h0, 1'b0);
        check_eq("t5_drop_end", 64'(key_dropped), 64'd0);
        cycle(1'b1, 4'h7, 1'b1);
        check_eq("t5_xfer_drop", 64'(key_dropped), 64'd1);
        check_eq("t3_xfer_valid", 64'(cmd_valid), 64'd0);
        check_eq("t3_xfer_f0", 64'(field_data[0 +: W]), 64'd0);
        check_eq("t3_xfer_f1", 64'(field_data[W +: W]), 64'd0);
        check_eq("t3_xfer_op", 64'(operation), 64'd1);
        cycle(1'b0, 4'h0, 1'b1);
        check_eq("t3_ready_idle", 64'(cmd_valid), 64'd0);

        // Saturation, backspace keeps ovf, clear drops it.
        seq = '{4'h2, 4'h5, 4'h6};
        foreach (seq[i]) press(seq[i]);
`ifdef KEYPAD_NEG_EN
        check_eq("t4_sat", 64'(field_data[0 +: W]), 64'd127);
`else
        check_eq("t4_sat", 64'(field_data[0 +: W]), 64'd255);
`endif
        check_eq("t4_ovf", 64'(ovf), 64'd1);
        press(4'hB);
`ifdef KEYPAD_NEG_EN
        check_eq("t4_bksp", 64'(field_data[0 +: W]), 64'd12);
`else
        check_eq("t4_bksp", 64'(field_data[0 +: W]), 64'd25);
`endif
        check_eq("t4_bksp_ovf", 64'(ovf), 64'd1);
        press(4'hC);
        check_eq("t4_clr", 64'(field_data[0 +: W]), 64'd0);
        check_eq("t4_clr_ovf", 64'(ovf), 64'd0);

        // Negate, then saturate the magnitude.
        seq = '{4'h1, 4'h2, 4'hF};
        foreach (seq[i]) press(seq[i]);
`ifdef KEYPAD_NEG_EN
        check_eq("t6_neg", 64'(field_data[0 +: W]), 64'hF4);
`else
        check_eq("t6_neg", 64'(field_data[0 +: W]), 64'd12);
`endif
        seq = '{4'h9, 4'h9, 4'h9};
        foreach (seq[i]) press(seq[i]);
`ifdef KEYPAD_NEG_EN
        check_eq("t6_negsat", 64'(field_data[0 +: W]), 64'h81);
`else
        check_eq("t6_negsat", 64'(field_data[0 +: W]), 64'hFF);
`endif
        check_eq("t6_ovf", 64'(ovf), 64'd1);
        press(4'hC);

        // Reset in HOLD drops the command immediately.
        press(4'h5);
        press(4'hD);
        check_eq("rst_pre_valid", 64'(cmd_valid), 64'd1);
        #2 reset = 1'b0;
        #1 check_eq("rst_async_valid", 64'(cmd_valid), 64'd0);
        model_reset();
        check_all();
        @(negedge clk);
        reset = 1'b1;
        cycle(1'b0, 4'h0, 1'b0);

        // Random traffic against the model.
        repeat (3000) begin
            cycle(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                  1'($urandom_range(0, 3) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
